sine_freq_meter: RTL and testbench

Zero-crossing frequency meter that recovers the oscillator frequency from the synthesized sample stream. It is the decoding end of the sinusoid oscillator: `Freq` goes in there, and this block measures the resulting samples back into a frequency estimate. It sits beside the oscillator in the Sys_clk domain, sampling on the same Syn_clk sample-tick strobe. It supports self-check on hardware and closed-loop testbenches.

---
 rtl/sine_freq_meter.sv | 202 ++++++++++++++++++++
 tb/tb_sine_freq_meter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : sine_freq_meter
//  Brief    : Zero-crossing frequency meter; times N_CYCLES waveform periods
//             in sample ticks and divides SAMPLE_RATE*N_CYCLES by that count.
//  Revision : 1.0 - initial release
// ============================================================================
module sine_freq_meter #(
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned N_CYCLES    = 4,
    parameter int unsigned HYST        = 16,
    parameter int unsigned MAX_TICKS   = 1048576
) (
    input  logic        Sys_clk,
    input  logic        Fm_rst_n,
    input  logic        Syn_clk,
    input  logic        Fm_ce,
    input  logic [31:0] Sample,
    output logic [31:0] Freq_est,
    output logic [31:0] Period_ticks,
    output logic        Freq_valid,
    output logic        Locked,
    output logic        Overrun
);

    localparam logic [31:0]        c_NUM       = 32'(SAMPLE_RATE * N_CYCLES);
    localparam logic [31:0]        c_MAX_TICKS = 32'(MAX_TICKS);
    localparam logic [6:0]         c_N_CYCLES  = 7'(N_CYCLES);
    localparam logic signed [31:0] c_HYST_POS  = 32'(HYST);
    localparam logic signed [31:0] c_HYST_NEG  = -c_HYST_POS;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_t;
    typedef enum logic [0:0] {DIV_IDLE = 1'b0, DIV_RUN = 1'b1} div_state_t;

    state_t      r_state, w_state_nxt;
    div_state_t  r_div_state, w_div_state_nxt;
    logic        r_armed;
    logic [31:0] r_tick, w_tick_nxt, w_tick_inc;
    logic [6:0]  r_cross_cnt, w_cross_nxt;
    logic [31:0] r_idle_cnt, w_idle_nxt;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_rem, r_quo, r_den;
    logic [31:0] r_freq_est, r_period;
    logic        r_freq_valid, r_locked, r_overrun;

    logic        w_low, w_high, w_cross;
    logic        w_close, w_timeout;
    logic        w_div_start, w_div_done, w_overrun;
    logic [32:0] w_rem_sh, w_diff;
    logic        w_ge;
    logic [31:0] w_rem_step, w_quo_step;

    assign w_low      = $signed(Sample) <= c_HYST_NEG;
    assign w_high     = $signed(Sample) >= c_HYST_POS;
    assign w_cross    = Fm_ce & Syn_clk & r_armed & w_high;
    assign w_tick_inc = r_tick + 32'd1;

    // Measurement FSM: window bookkeeping and timeout detection
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_cross_nxt = r_cross_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_close     = 1'b0;
        w_timeout   = 1'b0;
        if (!Fm_ce) begin
            w_state_nxt = ST_IDLE;
            w_tick_nxt  = 32'd0;
            w_cross_nxt = 7'd0;
            w_idle_nxt  = 32'd0;
        end else if (Syn_clk) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cross) begin
                        w_state_nxt = ST_MEASURE;
                        w_tick_nxt  = 32'd0;
                        w_cross_nxt = 7'd0;
                        w_idle_nxt  = 32'd0;
                    end else if (r_idle_cnt + 32'd1 >= c_MAX_TICKS) begin
                        w_timeout  = 1'b1;
                        w_idle_nxt = 32'd0;
                    end else begin
                        w_idle_nxt = r_idle_cnt + 32'd1;
                    end
                end
                ST_MEASURE: begin
                    // Timeout outranks a window closing on the same tick
                    if (w_tick_inc >= c_MAX_TICKS) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_tick_nxt  = 32'd0;
                        w_cross_nxt = 7'd0;
                    end else if (w_cross && (r_cross_cnt + 7'd1 == c_N_CYCLES)) begin
                        w_close     = 1'b1;
                        w_tick_nxt  = 32'd0;
                        w_cross_nxt = 7'd0;
                    end else begin
                        w_tick_nxt = w_tick_inc;
                        if (w_cross) w_cross_nxt = r_cross_cnt + 7'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Divider control runs alongside MEASURE; a busy divider drops new windows
    always_comb begin
        w_div_state_nxt = r_div_state;
        w_div_start     = 1'b0;
        w_div_done      = 1'b0;
        w_overrun       = 1'b0;
        if (!Fm_ce || w_timeout) begin
            w_div_state_nxt = DIV_IDLE;
        end else begin
            if (r_div_state == DIV_RUN && r_div_cnt == 5'd31) begin
                w_div_done      = 1'b1;
                w_div_state_nxt = DIV_IDLE;
            end
            if (w_close) begin
                if (r_div_state == DIV_RUN) begin
                    w_overrun = 1'b1;
                end else begin
                    w_div_start     = 1'b1;
                    w_div_state_nxt = DIV_RUN;
                end
            end
        end
    end

    assign w_rem_sh   = {r_rem, r_quo[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_den};
    assign w_ge       = ~w_diff[32];
    assign w_rem_step = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_step = {r_quo[30:0], w_ge};

    always_ff @(posedge Sys_clk or negedge Fm_rst_n) begin
        if (!Fm_rst_n) begin
            r_state     <= ST_IDLE;
            r_div_state <= DIV_IDLE;
            r_armed     <= 1'b0;
            r_tick      <= 32'd0;
            r_cross_cnt <= 7'd0;
            r_idle_cnt  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_state <= w_div_state_nxt;
            r_tick      <= w_tick_nxt;
            r_cross_cnt <= w_cross_nxt;
            r_idle_cnt  <= w_idle_nxt;
            if (!Fm_ce)         r_armed <= 1'b0;
            else if (w_cross)   r_armed <= 1'b0;
            else if (Syn_clk && w_low) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge Sys_clk or negedge Fm_rst_n) begin
        if (!Fm_rst_n) begin
            r_div_cnt    <= 5'd0;
            r_rem        <= 32'd0;
            r_quo        <= 32'd0;
            r_den        <= 32'd0;
            r_freq_est   <= 32'd0;
            r_period     <= 32'd0;
            r_freq_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_freq_valid <= w_div_done | w_timeout;
            r_overrun    <= w_overrun;
            if (w_div_start) begin
                r_div_cnt <= 5'd0;
                r_rem     <= 32'd0;
                r_quo     <= c_NUM;
                r_den     <= w_tick_inc;
            end else if (r_div_state == DIV_RUN) begin
                r_div_cnt <= r_div_cnt + 5'd1;
                r_rem     <= w_rem_step;
                r_quo     <= w_quo_step;
            end
            if (!Fm_ce) begin
                r_locked <= 1'b0;
            end else if (w_timeout) begin
                r_freq_est <= 32'd0;
                r_period   <= 32'd0;
                r_locked   <= 1'b0;
            end else if (w_div_done) begin
                r_freq_est <= w_quo_step;
                r_period   <= r_den;
                r_locked   <= (w_quo_step != 32'd0);
            end
        end
    end

    assign Freq_est     = r_freq_est;
    assign Period_ticks = r_period;
    assign Freq_valid   = r_freq_valid;
    assign Locked       = r_locked;
    assign Overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sine_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sine_freq_meter
//  Brief    : Directed bench for sine_freq_meter (square, sine, noise,
//             enable and reset corner cases).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sine_freq_meter;

    logic               Sys_clk = 1'b0;
    logic               Fm_rst_n;
    logic               Syn_clk;
    logic               Fm_ce;
    logic signed [31:0] Sample;
    logic [31:0]        Freq_est;
    logic [31:0]        Period_ticks;
    logic               Freq_valid;
    logic               Locked;
    logic               Overrun;

    sine_freq_meter #(
        .SAMPLE_RATE(48000),
        .N_CYCLES   (4),
        .HYST       (16),
        .MAX_TICKS  (4096)
    ) u_dut (
        .Sys_clk     (Sys_clk),
        .Fm_rst_n    (Fm_rst_n),
        .Syn_clk     (Syn_clk),
        .Fm_ce       (Fm_ce),
        .Sample      (Sample),
        .Freq_est    (Freq_est),
        .Period_ticks(Period_ticks),
        .Freq_valid  (Freq_valid),
        .Locked      (Locked),
        .Overrun     (Overrun)
    );

    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        int half;
        int gap;
        int amp;
        int exp_per;
        int exp_freq;
        int exp_intv;
        int exp_ovr;
    } vec_t;

    vec_t vecs [7];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    int   nvalid = 0;
    int   novr   = 0;
    int   valid_cyc [16];
    bit   prev_valid = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // One Sys_clk cycle: drive, clock, then observe the registered outputs
    task automatic cyc(input logic syn, input logic signed [31:0] s);
        Syn_clk = syn;
        Sample  = s;
        @(posedge Sys_clk);
        #1;
        cyc_no++;
        if (Freq_valid) begin
            if (nvalid < 16) valid_cyc[nvalid] = cyc_no;
            nvalid++;
            chk("valid_single_cycle", prev_valid, 0);
        end
        if (Overrun) novr++;
        prev_valid = Freq_valid;
    endtask

    function automatic logic signed [31:0] sq(input int half, input int amp, input int k);
        return ((k / half) % 2 == 0) ? amp : -amp;
    endfunction

    function automatic logic signed [31:0] sine_s(input int k);
        real ph;
        ph = 6.283185307179586 * k / 100.0;
        return $rtoi(1073741824.0 * $sin(ph));
    endfunction

    task automatic run_vec(input int idx);
        int k;
        int c;
        Fm_ce = 1'b0;
        repeat (3) cyc(1'b0, 32'sd0);
        Fm_ce  = 1'b1;
        nvalid = 0;
        novr   = 0;
        k = 0;
        c = 0;
        while (nvalid < 2 && c < 20000) begin
            if (c % vecs[idx].gap == 0) begin
                cyc(1'b1, sq(vecs[idx].half, vecs[idx].amp, k));
                k++;
            end else begin
                cyc(1'b0, 32'sd0);
            end
            c++;
        end
        chk($sformatf("vec%0d_got_results", idx), (nvalid >= 2) ? 1 : 0, 1);
        chk($sformatf("vec%0d_period", idx), Period_ticks, vecs[idx].exp_per);
        chk($sformatf("vec%0d_freq", idx), Freq_est, vecs[idx].exp_freq);
        chk($sformatf("vec%0d_locked", idx), Locked, 1);
        chk($sformatf("vec%0d_interval", idx), valid_cyc[1] - valid_cyc[0], vecs[idx].exp_intv);
        chk($sformatf("vec%0d_overruns", idx), novr, vecs[idx].exp_ovr);
    endtask

    initial begin
        int k;
        int c;
        int nv0;
        int cross_cyc;
        int target;

        vecs[0] = '{half: 24,  gap: 4, amp: 1000,   exp_per: 192, exp_freq: 1000,  exp_intv: 768, exp_ovr: 0};
        vecs[1] = '{half: 10,  gap: 1, amp: 1000,   exp_per: 80,  exp_freq: 2400,  exp_intv: 80,  exp_ovr: 0};
        vecs[2] = '{half: 25,  gap: 2, amp: 500000, exp_per: 200, exp_freq: 960,   exp_intv: 400, exp_ovr: 0};
        vecs[3] = '{half: 7,   gap: 3, amp: 1000,   exp_per: 56,  exp_freq: 3428,  exp_intv: 168, exp_ovr: 0};
        vecs[4] = '{half: 12,  gap: 2, amp: 16,     exp_per: 96,  exp_freq: 2000,  exp_intv: 192, exp_ovr: 0};
        vecs[5] = '{half: 100, gap: 1, amp: 30000,  exp_per: 800, exp_freq: 240,   exp_intv: 800, exp_ovr: 0};
        vecs[6] = '{half: 1,   gap: 1, amp: 1000,   exp_per: 8,   exp_freq: 24000, exp_intv: 40,  exp_ovr: 8};

        Fm_rst_n = 1'b0;
        Fm_ce    = 1'b0;
        Syn_clk  = 1'b0;
        Sample   = 32'sd0;
        repeat (2) cyc(1'b0, 32'sd0);
        chk("rst_freq", Freq_est, 0);
        chk("rst_period", Period_ticks, 0);
        chk("rst_valid", Freq_valid, 0);
        chk("rst_locked", Locked, 0);
        chk("rst_overrun", Overrun, 0);
        Fm_rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Sampled 480 Hz sine, three windows
        Fm_ce = 1'b0;
        repeat (3) cyc(1'b0, 32'sd0);
        Fm_ce  = 1'b1;
        nvalid = 0;
        k = 0;
        while (nvalid < 3 && k < 3000) begin
            nv0 = nvalid;
            cyc(1'b1, sine_s(k));
            k++;
            if (nvalid != nv0) begin
                chk("sine_period", Period_ticks, 400);
                chk("sine_freq", Freq_est, 480);
            end
        end
        chk("sine_windows", nvalid, 3);
        chk("sine_locked", Locked, 1);

        // Sub-threshold noise: first a MEASURE timeout, then an exact IDLE timeout
        nv0 = nvalid;
        c = 0;
        while (nvalid == nv0 && c < 6000) begin
            cyc(1'b1, int'($urandom_range(30, 0)) - 15);
            c++;
        end
        chk("noise_timeout_seen", (nvalid != nv0) ? 1 : 0, 1);
        chk("noise_freq", Freq_est, 0);
        chk("noise_period", Period_ticks, 0);
        chk("noise_locked", Locked, 0);
        nv0 = nvalid;
        c = 0;
        while (nvalid == nv0 && c < 6000) begin
            cyc(1'b1, int'($urandom_range(30, 0)) - 15);
            c++;
        end
        chk("idle_timeout_ticks", c, 4096);
        chk("idle_timeout_freq", Freq_est, 0);

        // Lock, then drop enable for 50 cycles while crossings keep arriving
        run_vec(0);
        k = 0;
        nv0 = nvalid;
        Fm_ce = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, sq(24, 1000, k));
            k++;
        end
        chk("ce_low_locked", Locked, 0);
        chk("ce_low_freq_held", Freq_est, 1000);
        chk("ce_low_period_held", Period_ticks, 192);
        chk("ce_low_no_valid", nvalid - nv0, 0);
        Fm_ce = 1'b1;
        k = 0;
        cross_cyc = 0;
        c = 0;
        while (nvalid == nv0 && c < 2000) begin
            if (k == 48) cross_cyc = cyc_no;
            cyc(1'b1, sq(24, 1000, k));
            k++;
            c++;
        end
        chk("ce_relock_seen", (nvalid != nv0) ? 1 : 0, 1);
        chk("ce_relock_latency", cyc_no - cross_cyc, 192 + 33);
        chk("ce_relock_freq", Freq_est, 1000);
        chk("ce_relock_locked", Locked, 1);

        // Asynchronous reset ten cycles into the next divide
        target = cross_cyc + 384 + 10;
        c = 0;
        while (cyc_no < target && c < 2000) begin
            cyc(1'b1, sq(24, 1000, k));
            k++;
            c++;
        end
        chk("prerst_reached", cyc_no, target);
        chk("prerst_locked", Locked, 1);
        #2 Fm_rst_n = 1'b0;
        #1;
        chk("midrst_freq", Freq_est, 0);
        chk("midrst_period", Period_ticks, 0);
        chk("midrst_locked", Locked, 0);
        chk("midrst_valid", Freq_valid, 0);
        nv0 = nvalid;
        repeat (3) cyc(1'b0, 32'sd0);
        Fm_rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, sq(24, 1000, k));
            k++;
        end
        chk("postrst_no_valid", nvalid - nv0, 0);
        chk("postrst_freq", Freq_est, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
